conv_window_gen: RTL and testbench

- Streaming sliding-window generator; sits directly upstream of the convolution reduction tree.
- Accepts one pixel per cycle in row-major order and keeps KERNEL-1 line buffers plus a KERNEL x KERNEL shift window.
- Emits a flattened KERNEL*KERNEL window for every valid (no-padding) output position.
- With KERNEL=3 it produces exactly the 9 operands the downstream multiply/reduce path consumes.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_line_buffer.sv | 26 ++
 rtl/conv_window_gen.sv | 157 +++++++++++++++
 tb/tb_conv_window_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution path: window FSM states and default geometry.
// Default KERNEL/DATA_WIDTH match the reduction tree; win_elems gives the operand count.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } window_state_e;

    localparam int DEF_KERNEL     = 3;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int WIN_ELEMS      = DEF_KERNEL * DEF_KERNEL;

    function automatic int win_elems(input int kernel);
        return kernel * kernel;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Purpose: one image row of delay, circular buffer indexed by column.
// Latency: read is combinational at addr (previous row's pixel); write lands next edge.
// Backpressure: none internally; wr_en is the parent's accepted-pixel strobe.
module conv_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [AW-1:0]                addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic signed [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Purpose: streaming KERNELxKERNEL sliding-window generator; optional stall_cnt via CONV_WINDOW_GEN_STALL_CNT_EN.
// Latency: window registered on the edge its completing pixel is accepted; out_valid the cycle after.
// Backpressure: single output register; in_ready drops while a window is held and out_ready is low.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int KERNEL     = DEF_KERNEL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_window [0:KERNEL*KERNEL-1],
    output logic                         frame_done
`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int NW = win_elems(KERNEL);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          out_xfer;
    logic          last_col;
    logic          last_row;
    logic          win_px;

    // col_in[0] is the oldest row of the current column, col_in[KERNEL-1] the live pixel
    logic signed [DATA_WIDTH-1:0] col_in [0:KERNEL-1];
    logic signed [DATA_WIDTH-1:0] sw     [0:KERNEL-1][0:KERNEL-2];

    assign in_ready   = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DRAIN) && out_xfer;
    assign last_col   = (col == CW'(IMG_W - 1));
    assign last_row   = (row == RW'(IMG_H - 1));
    // Row gating also keeps stale line-buffer data from a previous frame out of every window
    assign win_px     = (row >= RW'(KERNEL - 1)) && (col >= CW'(KERNEL - 1));

    assign col_in[KERNEL-1] = in_data;

    for (genvar k = 0; k < KERNEL - 1; k++) begin : g_lb
        conv_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_W)
        ) u_lb (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (col),
            .wr_data (col_in[KERNEL-1-k]),
            .rd_data (col_in[KERNEL-2-k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row   <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_xfer) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Columns left of KERNEL-1 in a row never emit, so sw needs no clear at row start
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < KERNEL; i++) begin
                for (int j = 0; j < KERNEL - 2; j++) begin
                    sw[i][j] <= sw[i][j+1];
                end
                sw[i][KERNEL-2] <= col_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            for (int e = 0; e < NW; e++) begin
                out_window[e] <= '0;
            end
        end else if (accept && win_px) begin
            out_valid <= 1'b1;
            for (int i = 0; i < KERNEL; i++) begin
                for (int j = 0; j < KERNEL - 1; j++) begin
                    out_window[i*KERNEL+j] <= sw[i][j];
                end
                out_window[i*KERNEL+KERNEL-1] <= col_in[i];
            end
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen at KERNEL=3 on a 4x4 frame.
// Inputs change just after rising edges; outputs are sampled on falling edges.
module tb_conv_window_gen;

    localparam int K  = 3;
    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 busy;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_window [0:K*K-1];
    logic                 frame_done;
`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int win_q[$];
    int fd_cnt;
    int fd_at;
    int cyc = 0;
    int acc10;
    int first_ov;

    always #5 clk = ~clk;

    conv_window_gen #(
        .KERNEL     (K),
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .frame_done (frame_done)
`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready && in_data == 10 && acc10 < 0) acc10 = cyc;
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                for (int e = 0; e < K*K; e++) win_q.push_back(int'(out_window[e]));
            end
            if (frame_done) begin
                fd_cnt++;
                fd_at = win_q.size();
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Window w covers output position (2 + w/2, 2 + w%2); element e = i*3 + j
    function automatic int exp_px(input int base, input int neg_idx, input int w, input int e);
        int p;
        p = (w / 2 + e / 3) * W + (w % 2 + e % 3);
        return (p == neg_idx) ? -32768 : base + p;
    endfunction

    task automatic clear_mon();
        win_q.delete();
        fd_cnt   = 0;
        fd_at    = -1;
        acc10    = -1;
        first_ov = -1;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit bubbles, input int neg_idx, input int npx);
        int p = 0;
        int g = 0;
        bit acc;
        while (p < npx && g < 2000) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = (p == neg_idx) ? 16'sh8000 : 16'(base + p);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) p++;
            g++;
        end
        in_valid = 1'b0;
        chk("send_done", p, npx);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic check_frame(input string tag, input int base, input int neg_idx);
        chk({tag, "_nwin"}, win_q.size() / 9, 4);
        chk({tag, "_fdone_cnt"}, fd_cnt, 1);
        chk({tag, "_fdone_at_last"}, fd_at, 36);
        for (int w = 0; w < 4; w++) begin
            for (int e = 0; e < 9; e++) begin
                if (w * 9 + e < win_q.size())
                    chk($sformatf("%s_w%0d_e%0d", tag, w, e), win_q[w*9+e], exp_px(base, neg_idx, w, e));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        clear_mon();
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_win0", int'(out_window[0]), 0);
        chk("rst_win8", int'(out_window[8]), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic frame, no backpressure
        clear_mon();
        do_start();
        chk("basic_busy", int'(busy), 1);
        chk("basic_in_ready", int'(in_ready), 1);
        send_frame(0, 1'b0, -1, 16);
        wait_idle("basic");
        check_frame("basic", 0, -1);
        chk("basic_latency", first_ov - acc10, 1);

        // Backpressure on the first window
        clear_mon();
        out_ready = 1'b0;
        do_start();
        fork
            send_frame(0, 1'b0, -1, 16);
            begin
                int g = 0;
                @(negedge clk);
                while (!out_valid && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                chk("bp_out_valid", int'(out_valid), 1);
                for (int s = 0; s < 5; s++) begin
                    if (s > 0) @(negedge clk);
                    chk("bp_hold_w0", int'(out_window[0]), 0);
                    chk("bp_hold_w4", int'(out_window[4]), 5);
                    chk("bp_hold_w8", int'(out_window[8]), 10);
                    chk("bp_in_ready", int'(in_ready), 0);
                end
                @(posedge clk); #2 out_ready = 1'b1;
            end
        join
        wait_idle("bp");
        check_frame("bp", 0, -1);
`ifdef CONV_WINDOW_GEN_STALL_CNT_EN
        chk("bp_stall_cnt", int'(stall_cnt), 5);
`endif

        // Input bubbles
        clear_mon();
        do_start();
        send_frame(0, 1'b1, -1, 16);
        wait_idle("bubble");
        check_frame("bubble", 0, -1);

        // Back-to-back frames
        clear_mon();
        do_start();
        send_frame(0, 1'b0, -1, 16);
        wait_idle("b2b_f1");
        clear_mon();
        do_start();
        send_frame(100, 1'b0, -1, 16);
        wait_idle("b2b_f2");
        check_frame("b2b", 100, -1);

        // Reset mid-frame
        clear_mon();
        do_start();
        send_frame(0, 1'b0, -1, 6);
        chk("mrst_busy_pre", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_stay_idle", int'(busy), 0);
        clear_mon();
        do_start();
        send_frame(0, 1'b0, -1, 16);
        wait_idle("mrst");
        check_frame("mrst", 0, -1);

        // Start during RUN is ignored; most negative pixel passes through
        clear_mon();
        do_start();
        fork
            send_frame(200, 1'b0, 5, 16);
            begin
                repeat (4) @(posedge clk);
                #3 start = 1'b1;
                @(posedge clk); #3 start = 1'b0;
                chk("ign_busy", int'(busy), 1);
            end
        join
        wait_idle("ign");
        check_frame("ign", 200, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
